// File: rtl/syncnt_down.sv
// Loadable synchronous down-counter/timer with one-shot or auto-reload expiry.
// TC pulses for one cycle per expiry; Q, TC and RUN are all registered.
module syncnt_down #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  input  logic             LDL,
  input  logic             CE,
  input  logic             START,
  input  logic             STOP,
  input  logic             AUTO,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             RUN
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             tc_q, tc_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      tc_q    <= tc_d;
    end
  end

  // Event priority: load, then stop, then start (from IDLE only), then count.
  // START while already running falls through so counting is not stalled.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    tc_d    = 1'b0;
    if (!LDL) begin
      r_d = D;
      q_d = D;
    end else if (STOP) begin
      state_d = S_IDLE;
    end else if (START && state_q == S_IDLE) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN && CE) begin
      if (q_q != '0) begin
        q_d = q_q - 1'b1;
      end else begin
        // Zero is always an expiry point, never a wrap.
        tc_d = 1'b1;
        if (AUTO) q_d = r_q;
        else      state_d = S_IDLE;
      end
    end
  end

  assign Q   = q_q;
  assign TC  = tc_q;
  assign RUN = (state_q == S_RUN);

endmodule
